// File: rtl/xilinx_primitive_pkg.sv
// Shared constants and helpers for Xilinx primitive wrappers.
// Read-latency limits and skid-buffer sizing live here.
package xilinx_primitive_pkg;

    localparam int MAX_READ_LATENCY = 3;
    localparam int MAX_BUF_DEPTH    = 8;
    localparam int OCC_W            = 4;
    localparam int CREDIT_W         = 5;

    function automatic int get_rd_buf_depth(input int latency);
        return latency + 1;
    endfunction

endpackage

// File: rtl/xilinx_stream_skid_buf.sv
// Register-based circular FIFO that absorbs words already requested
// from the primitive FIFO while the stream sink is stalled.
module xilinx_stream_skid_buf
    import xilinx_primitive_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [OCC_W-1:0]      occupancy,
    output logic                  empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_pop;

    assign empty     = (occupancy == '0);
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, do_pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/xilinx_fifo_rd_stream.sv
// Turns a fixed-latency FIFO read port into a valid/ready stream,
// using credits so every issued read has a guaranteed buffer slot.
module xilinx_fifo_rd_stream
    import xilinx_primitive_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int READ_LATENCY = 2,
    parameter int BUF_DEPTH    = get_rd_buf_depth(READ_LATENCY)
) (
    input  logic                  RDCLK,
    input  logic                  RST_N,
    input  logic                  ENABLE,
    input  logic                  EMPTY,
    input  logic                  RDERR,
    input  logic [DATA_WIDTH-1:0] DO,
    output logic                  RDEN,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic [31:0]           WORD_COUNT,
    output logic                  ERR
);

    localparam logic [CREDIT_W-1:0] DEPTH_C = CREDIT_W'(BUF_DEPTH);

    logic [READ_LATENCY-1:0] rd_pipe;
    logic [CREDIT_W-1:0]     inflight;
    logic [CREDIT_W-1:0]     credits;
    logic [OCC_W-1:0]        occ;
    logic                    buf_empty;
    logic [DATA_WIDTH-1:0]   head;
    logic                    xfer;
    logic [31:0]             word_cnt;
    logic                    err_q;

    assign xfer = M_VALID & M_READY;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CREDIT_W'(rd_pipe[i]);
        end
        credits = inflight + CREDIT_W'(occ) - CREDIT_W'(xfer);
    end

    // Gated by reset so no read is issued while state is being cleared.
    assign RDEN = RST_N & ENABLE & ~EMPTY & (credits < DEPTH_C);

    always_ff @(posedge RDCLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= RDEN;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    xilinx_stream_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (BUF_DEPTH)
    ) u_skid_buf (
        .clk      (RDCLK),
        .rst_n    (RST_N),
        .push     (rd_pipe[READ_LATENCY-1]),
        .push_data(DO),
        .pop      (xfer),
        .head_data(head),
        .occupancy(occ),
        .empty    (buf_empty)
    );

    assign M_VALID = ~buf_empty;
    assign M_DATA  = buf_empty ? '0 : head;

    always_ff @(posedge RDCLK or negedge RST_N) begin
        if (!RST_N) begin
            word_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (xfer) begin
                word_cnt <= word_cnt + 32'd1;
            end
            if (RDERR) begin
                err_q <= 1'b1;
            end
        end
    end

    assign WORD_COUNT = word_cnt;
    assign ERR        = err_q;

endmodule

// File: tb/tb_xilinx_fifo_rd_stream.sv
// Randomised scoreboard bench for xilinx_fifo_rd_stream with a
// behavioural primitive-FIFO model driving EMPTY/DO.
module tb_xilinx_fifo_rd_stream;

    localparam int DW = 4;
    localparam int RL = 2;
    localparam int BD = RL + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          rderr = 1'b0;
    logic          m_ready = 1'b0;
    logic          empty;
    logic [DW-1:0] do_w;
    logic          rden;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [31:0]   word_count;
    logic          err;

    always #5 clk = ~clk;

    xilinx_fifo_rd_stream #(
        .DATA_WIDTH  (DW),
        .READ_LATENCY(RL),
        .BUF_DEPTH   (BD)
    ) dut (
        .RDCLK     (clk),
        .RST_N     (rst_n),
        .ENABLE    (enable),
        .EMPTY     (empty),
        .RDERR     (rderr),
        .DO        (do_w),
        .RDEN      (rden),
        .M_VALID   (m_valid),
        .M_READY   (m_ready),
        .M_DATA    (m_data),
        .WORD_COUNT(word_count),
        .ERR       (err)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(string name, longint act, longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endfunction

    // Primitive FIFO model: storage plus a fixed-latency read pipe.
    logic [DW-1:0] fmem [256];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic [DW-1:0] dch [RL];

    assign empty = (rd_ptr == wr_ptr);
    assign do_w  = dch[RL-1];

    always @(posedge clk) begin
        if (!rst_n) rd_ptr <= wr_ptr;
        else if (rden) rd_ptr <= rd_ptr + 1;
        dch[0] <= rden ? fmem[rd_ptr % 256] : DW'($urandom);
        for (int i = 1; i < RL; i++) dch[i] <= dch[i-1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: words leave in the order they were written.
    logic [DW-1:0] exp_q [$];
    logic [31:0]   cnt_model = 0;

    task automatic push_word(input logic [DW-1:0] w);
        fmem[wr_ptr % 256] = w;
        wr_ptr++;
        exp_q.push_back(w);
    endtask

    logic          pv = 1'b0;
    logic          pr = 1'b1;
    logic [DW-1:0] pd = '0;
    int rden_cnt = 0;
    int xfer_cnt = 0;
    int first_rden = -1;
    int first_valid = -1;
    int first_xfer = -1;
    int last_xfer = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cnt_model = 0;
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, pd);
            end
            if (rden) begin
                rden_cnt++;
                if (first_rden < 0) first_rden = cyc;
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                chk("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("word_data", m_data, exp_q.pop_front());
                chk("word_count", word_count, cnt_model);
                cnt_model = cnt_model + 1;
                xfer_cnt++;
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
            end
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < budget) begin
            tick(1);
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset holds everything quiet even with data available.
        rst_n = 0;
        enable = 1;
        m_ready = 1;
        tick(1);
        push_word(4'h5);
        push_word(4'h6);
        #2;
        chk("rst_rden", rden, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_count", word_count, 0);
        chk("rst_err", err, 0);
        tick(2);
        rst_n = 1;
        tick(2);

        // Burst of ten with the sink always ready.
        first_rden = -1;
        first_valid = -1;
        first_xfer = -1;
        xfer_cnt = 0;
        for (int i = 1; i <= 10; i++) push_word(DW'(i));
        wait_idle("burst_drain", 60);
        chk("burst_latency", first_valid - first_rden, RL + 1);
        chk("burst_span", last_xfer - first_xfer, 9);
        chk("burst_xfers", xfer_cnt, 10);
        chk("burst_count", word_count, 10);

        // Backpressure: only BD reads may be issued.
        m_ready = 0;
        rden_cnt = 0;
        xfer_cnt = 0;
        for (int i = 0; i < 8; i++) push_word(DW'($urandom));
        tick(20);
        chk("bp_rden", rden_cnt, BD);
        chk("bp_xfers", xfer_cnt, 0);
        chk("bp_valid", m_valid, 1);
        m_ready = 1;
        wait_idle("bp_drain", 60);

        // ENABLE dropped with two reads in flight.
        enable = 0;
        for (int i = 0; i < 5; i++) push_word(DW'($urandom));
        tick(1);
        rden_cnt = 0;
        xfer_cnt = 0;
        enable = 1;
        tick(2);
        enable = 0;
        tick(12);
        chk("en_rden", rden_cnt, 2);
        chk("en_xfers", xfer_cnt, 2);
        chk("en_valid", m_valid, 0);
        enable = 1;
        wait_idle("en_drain", 60);

        // Sticky read error.
        rderr = 1;
        tick(1);
        rderr = 0;
        tick(3);
        chk("err_set", err, 1);

        // Reset with two words buffered and one in flight.
        m_ready = 0;
        enable = 0;
        for (int i = 0; i < 6; i++) push_word(DW'($urandom));
        tick(1);
        enable = 1;
        tick(4);
        chk("pre_rst_valid", m_valid, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_count", word_count, 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_rden", rden, 0);
        chk("mid_rst_err", err, 0);
        tick(1);
        rst_n = 1;
        m_ready = 1;
        tick(6);
        chk("post_rst_valid", m_valid, 0);
        chk("post_rst_count", word_count, 0);
        push_word(4'h9);
        push_word(4'h3);
        push_word(4'hC);
        wait_idle("post_rst_drain", 60);
        chk("post_rst_count3", word_count, 3);

        // Random enable, backpressure and write traffic.
        for (int c = 0; c < 400; c++) begin
            enable = ($urandom % 4) != 0;
            m_ready = ($urandom % 3) != 0;
            if (($urandom % 2) != 0 && exp_q.size() < 100)
                push_word(DW'($urandom));
            tick(1);
        end
        enable = 1;
        m_ready = 1;
        wait_idle("rand_drain", 400);
        chk("rand_count", word_count, cnt_model);

        // Counter wrap.
        force dut.word_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.word_cnt;
        cnt_model = 32'hFFFF_FFFE;
        chk("wrap_preset", word_count, 32'hFFFF_FFFE);
        push_word(4'h1);
        push_word(4'h2);
        wait_idle("wrap_drain", 60);
        chk("wrap_count", word_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
